// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC stage.
// Holds the FSM encoding and the accumulator sizing rule.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_KSIZE = 4;

  // Smallest width that holds k maximal unsigned products.
  function automatic int acc_width(input int k, input int dw);
    longint mx;
    longint top;
    int w;
    top = (longint'(1) << dw) - 1;
    mx  = longint'(k) * top * top;
    w   = 0;
    for (int i = 0; i < 63; i++) begin
      if ((longint'(1) << i) > mx) begin
        w = i;
        break;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/conv_mac_unit_if.sv
// Tap stream in, window sums out, for the convolution MAC stage.
// master drives taps and sees results; slave is the MAC itself.
interface conv_mac_if #(
  parameter int DW = 8,
  parameter int AW = 18
);
  logic          in_valid;
  logic [DW-1:0] filter_in;
  logic [DW-1:0] pixel_in;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_data;

  modport master (
    output in_valid,
    output filter_in,
    output pixel_in,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  filter_in,
    input  pixel_in,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/conv_mac_unit_mac_cell.sv
// Registered multiply-accumulate: first tap loads, later taps add.
// sum_o is the value the accumulator takes on an enabled edge.
module mac_cell
  import conv_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          first,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] sum_o
);

  logic [2*DW-1:0] prod_w;
  logic [AW-1:0]   prod;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;

  always_comb begin
    prod_w = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    prod   = AW'(prod_w);
    sum_o  = first ? prod : acc_q + prod;
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_mac_unit.sv
// Convolution MAC stage: sums KSIZE taps per window, NWIN windows per frame.
// Frame FSM and tap/window counters; the datapath sits in mac_cell.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int KSIZE = DEF_KSIZE,
  parameter int NWIN  = 9,
  parameter int DW    = DEF_DW,
  parameter int AW    = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  conv_mac_if.slave   bus,
  output logic        done,
  output logic [1:0]  state
);

  localparam int TW = $clog2(KSIZE);

  if (AW < acc_width(KSIZE, DW)) begin : g_aw_chk
    $error("conv_mac_unit: AW too narrow for KSIZE/DW");
  end

  state_e        state_q;
  state_e        state_d;
  logic [TW-1:0] tap_q;
  logic [TW-1:0] tap_d;
  logic [7:0]    win_q;
  logic [7:0]    win_d;
  logic [AW-1:0] out_data_q;
  logic [AW-1:0] out_data_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic          done_q;
  logic          done_d;

  logic          accum;
  logic          take;
  logic          first;
  logic          last_tap;
  logic          last_win;
  logic          mac_clr;
  logic [AW-1:0] sum;

  assign accum    = (state_q == ST_ACCUM);
  assign take     = accum && bus.in_valid;
  assign first    = (tap_q == '0);
  assign last_tap = (tap_q == TW'(KSIZE - 1));
  assign last_win = (win_q == 8'(NWIN - 1));

  mac_cell #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (take),
    .clr  (mac_clr),
    .first(first),
    .a    (bus.filter_in),
    .b    (bus.pixel_in),
    .sum_o(sum)
  );

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    win_d       = win_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    mac_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          tap_d   = '0;
          win_d   = '0;
          mac_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          if (last_tap) begin
            tap_d       = '0;
            win_d       = win_q + 8'd1;
            out_data_d  = sum;
            out_valid_d = 1'b1;
            if (last_win) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      win_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      win_q       <= win_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = accum;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign done          = done_q;
  assign state         = state_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit: single-window and full-frame instances.
// Expected window sums are queued at stimulus time and popped on out_valid.
module tb_conv_mac_unit;
  import conv_pkg::*;

  localparam int DW = 8;
  localparam int AW = 18;
  localparam int K  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sa  = 1'b0;
  logic       sb  = 1'b0;
  logic       da;
  logic       db;
  logic [1:0] sta;
  logic [1:0] stb;

  int checks   = 0;
  int errors   = 0;
  int b_pulses = 0;
  int b_dones  = 0;

  logic [AW-1:0] qa[$];
  logic [AW-1:0] qb[$];

  conv_mac_if #(.DW(DW), .AW(AW)) ifa ();
  conv_mac_if #(.DW(DW), .AW(AW)) ifb ();

  conv_mac_unit #(
    .KSIZE(K), .NWIN(1), .DW(DW), .AW(AW)
  ) u_a (
    .clk(clk), .rst(rst), .start(sa),
    .bus(ifa), .done(da), .state(sta)
  );

  conv_mac_unit #(
    .KSIZE(K), .NWIN(9), .DW(DW), .AW(AW)
  ) u_b (
    .clk(clk), .rst(rst), .start(sb),
    .bus(ifb), .done(db), .state(stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic s, input logic v,
                       input logic [7:0] f, input logic [7:0] p);
    sa            = s;
    ifa.in_valid  = v;
    ifa.filter_in = f;
    ifa.pixel_in  = p;
    @(negedge clk);
  endtask

  task automatic drv_b(input logic s, input logic v,
                       input logic [7:0] f, input logic [7:0] p);
    sb            = s;
    ifb.in_valid  = v;
    ifb.filter_in = f;
    ifb.pixel_in  = p;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (ifa.out_valid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("sb_a_unexpected", 32'(ifa.out_data), 32'hFFFF_FFFF);
      end else begin
        chk("sb_a_data", 32'(ifa.out_data), 32'(qa.pop_front()));
      end
    end
    if (ifb.out_valid === 1'b1) begin
      b_pulses++;
      if (qb.size() == 0) begin
        chk("sb_b_unexpected", 32'(ifb.out_data), 32'hFFFF_FFFF);
      end else begin
        chk("sb_b_data", 32'(ifb.out_data), 32'(qb.pop_front()));
      end
    end
    if (db === 1'b1) b_dones++;
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.filter_in = '0; ifa.pixel_in = '0;
    ifb.in_valid = 1'b0; ifb.filter_in = '0; ifb.pixel_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state_a", 32'(sta), 0);
    chk("rst_ov_a", 32'(ifa.out_valid), 0);
    chk("rst_done_a", 32'(da), 0);
    chk("rst_data_a", 32'(ifa.out_data), 0);
    chk("rst_ready_a", 32'(ifa.in_ready), 0);
    chk("rst_state_b", 32'(stb), 0);
    rst = 1'b0;

    // taps offered in IDLE are dropped
    drv_a(0, 1, 200, 200);
    drv_a(0, 1, 200, 200);
    chk("idle_state", 32'(sta), 0);
    chk("idle_ready", 32'(ifa.in_ready), 0);
    chk("idle_ov", 32'(ifa.out_valid), 0);

    // single window; tap coincident with start is dropped
    drv_a(1, 1, 99, 99);
    chk("start_state", 32'(sta), 1);
    chk("start_ready", 32'(ifa.in_ready), 1);
    qa.push_back(300);
    drv_a(0, 1, 1, 10);
    drv_a(0, 1, 2, 20);
    drv_a(0, 1, 3, 30);
    chk("win_pre_ov", 32'(ifa.out_valid), 0);
    drv_a(0, 1, 4, 40);
    chk("win_ov", 32'(ifa.out_valid), 1);
    chk("win_done", 32'(da), 1);
    chk("win_state", 32'(sta), 2);
    chk("win_ready", 32'(ifa.in_ready), 0);
    drv_a(1, 1, 5, 5);
    chk("done_pulse", 32'(da), 0);
    chk("done_ov", 32'(ifa.out_valid), 0);
    chk("done_start_ign", 32'(sta), 0);
    chk("data_hold", 32'(ifa.out_data), 300);

    // maximum operands
    drv_a(1, 0, 0, 0);
    qa.push_back(260100);
    repeat (4) drv_a(0, 1, 255, 255);
    chk("max_ov", 32'(ifa.out_valid), 1);
    chk("max_done", 32'(da), 1);
    drv_a(0, 0, 0, 0);

    // three-cycle stall between taps 2 and 3
    drv_a(1, 0, 0, 0);
    qa.push_back(300);
    drv_a(0, 1, 1, 10);
    drv_a(0, 1, 2, 20);
    for (int i = 0; i < 3; i++) begin
      drv_a(0, 0, 77, 77);
      chk("stall_ov", 32'(ifa.out_valid), 0);
      chk("stall_state", 32'(sta), 1);
    end
    drv_a(0, 1, 3, 30);
    chk("stall_pre_ov", 32'(ifa.out_valid), 0);
    drv_a(0, 1, 4, 40);
    chk("stall_ov_end", 32'(ifa.out_valid), 1);
    drv_a(0, 0, 0, 0);

    // start while accumulating must not restart the frame
    drv_a(1, 0, 0, 0);
    qa.push_back(300);
    drv_a(0, 1, 1, 10);
    drv_a(1, 1, 2, 20);
    drv_a(1, 0, 0, 0);
    chk("acc_start_state", 32'(sta), 1);
    chk("acc_start_ov", 32'(ifa.out_valid), 0);
    drv_a(0, 1, 3, 30);
    drv_a(0, 1, 4, 40);
    chk("acc_start_fin", 32'(ifa.out_valid), 1);
    chk("acc_start_done", 32'(da), 1);
    drv_a(0, 0, 0, 0);

    // reset after two accepted taps
    drv_a(1, 0, 0, 0);
    drv_a(0, 1, 255, 255);
    drv_a(0, 1, 255, 255);
    rst = 1'b1;
    drv_a(0, 1, 255, 255);
    rst = 1'b0;
    chk("mid_rst_state", 32'(sta), 0);
    chk("mid_rst_ov", 32'(ifa.out_valid), 0);
    chk("mid_rst_done", 32'(da), 0);
    chk("mid_rst_data", 32'(ifa.out_data), 0);
    chk("mid_rst_ready", 32'(ifa.in_ready), 0);
    drv_a(1, 0, 0, 0);
    qa.push_back(300);
    drv_a(0, 1, 1, 10);
    drv_a(0, 1, 2, 20);
    drv_a(0, 1, 3, 30);
    drv_a(0, 1, 4, 40);
    chk("post_rst_ov", 32'(ifa.out_valid), 1);
    drv_a(0, 0, 0, 0);

    // full frame of nine windows on the second instance
    drv_b(1, 0, 0, 0);
    chk("frame_state", 32'(stb), 1);
    for (int i = 0; i < 36; i++) begin
      if (i % 4 == 0) qb.push_back(10);
      drv_b(0, 1, 8'(i % 4 + 1), 8'd1);
      chk("frame_ov", 32'(ifb.out_valid), 32'(i % 4 == 3));
      chk("frame_done", 32'(db), 32'(i == 35));
    end
    drv_b(0, 0, 0, 0);
    chk("frame_end_state", 32'(stb), 0);
    chk("frame_end_done", 32'(db), 0);
    drv_b(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);

    chk("b_pulses", 32'(b_pulses), 9);
    chk("b_dones", 32'(b_dones), 1);
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
